spi_slave_resp: RTL and testbench



---
 rtl/spi_slave_resp.sv | 158 +++++++++++++++
 tb/tb_spi_slave_resp.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_resp.sv
// SPI responder: oversamples ss/sck/mosi into clk, supports all four CPOL/CPHA
// modes, deserializes MSB-first words and serializes tx words onto miso.
module spi_slave_resp #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic                  ss,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_abort,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic                  r_ss_s1, r_ss_s2, r_ss_s3;
  logic                  r_sck_s1, r_sck_s2, r_sck_s3;
  logic                  r_mosi_s1, r_mosi_s2;
  logic [1:0]            r_fill;
  logic                  r_armed;
  logic [0:0]            r_state;
  logic                  r_cpol, r_cpha;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_rx_sr;
  logic [DATA_WIDTH-1:0] r_tx_sr;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid, r_rx_abort, r_tx_ready, r_tx_underrun;

  logic                  w_active;
  logic                  w_ss_fall, w_ss_rise, w_sck_rise, w_sck_fall;
  logic                  w_lead, w_trail, w_sample, w_shift;
  logic                  w_last, w_load;
  logic [CW-1:0]         w_cnt_next;
  logic [DATA_WIDTH-1:0] w_rx_word;

  // A fall is only honoured once the pin has been seen high after reset, so a
  // master still holding ss low through reset cannot re-enter mid-transfer.
  assign w_ss_fall  = r_armed & ~r_ss_s2 & r_ss_s3;
  assign w_ss_rise  = r_ss_s2 & ~r_ss_s3;
  assign w_sck_rise = r_sck_s2 & ~r_sck_s3;
  assign w_sck_fall = ~r_sck_s2 & r_sck_s3;

  assign w_active = (r_state == ST_ACTIVE);
  assign w_lead   = r_cpol ? w_sck_fall : w_sck_rise;
  assign w_trail  = r_cpol ? w_sck_rise : w_sck_fall;
  assign w_sample = w_active & (r_cpha ? w_trail : w_lead);
  // Deselect wins over a coincident shift edge: no word is started as ss rises.
  assign w_shift  = w_active & ~w_ss_rise & (r_cpha ? w_lead : w_trail);

  assign w_last     = (r_cnt == LAST_BIT);
  assign w_cnt_next = w_sample ? (w_last ? '0 : r_cnt + CW'(1)) : r_cnt;
  assign w_rx_word  = {r_rx_sr[DATA_WIDTH-2:0], r_mosi_s2};

  // Counter is zero on a shift edge only at a word boundary in either phase.
  assign w_load = (w_shift & (r_cnt == '0)) |
                  (~w_active & w_ss_fall & ~mode[0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ss_s1       <= 1'b1;
      r_ss_s2       <= 1'b1;
      r_ss_s3       <= 1'b1;
      r_sck_s1      <= 1'b0;
      r_sck_s2      <= 1'b0;
      r_sck_s3      <= 1'b0;
      r_mosi_s1     <= 1'b0;
      r_mosi_s2     <= 1'b0;
      r_fill        <= 2'd0;
      r_armed       <= 1'b0;
      r_state       <= ST_IDLE;
      r_cpol        <= 1'b0;
      r_cpha        <= 1'b0;
      r_cnt         <= '0;
      r_rx_sr       <= '0;
      r_tx_sr       <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_abort    <= 1'b0;
      r_tx_ready    <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_ss_s1   <= ss;
      r_ss_s2   <= r_ss_s1;
      r_ss_s3   <= r_ss_s2;
      r_sck_s1  <= sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_s3  <= r_sck_s2;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;

      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
      if (r_fill == 2'd3 && r_ss_s3) r_armed <= 1'b1;

      r_rx_valid    <= 1'b0;
      r_rx_abort    <= 1'b0;
      r_tx_ready    <= 1'b0;
      r_tx_underrun <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_ss_fall) begin
            r_state <= ST_ACTIVE;
            r_cpol  <= mode[1];
            r_cpha  <= mode[0];
            r_cnt   <= '0;
          end
        end
        default: begin
          if (w_sample) begin
            r_rx_sr <= w_rx_word;
            if (w_last) begin
              r_rx_data  <= w_rx_word;
              r_rx_valid <= 1'b1;
            end
          end
          r_cnt <= w_cnt_next;
          if (w_ss_rise) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rx_abort <= (w_cnt_next != '0);
          end
        end
      endcase

      if (w_load) begin
        r_tx_sr       <= tx_valid ? tx_data : '0;
        r_tx_ready    <= tx_valid;
        r_tx_underrun <= ~tx_valid;
      end else if (w_shift) begin
        r_tx_sr <= {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign miso        = w_active & r_tx_sr[DATA_WIDTH-1];
  assign miso_oe     = w_active;
  assign busy        = w_active;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_abort    = r_rx_abort;
  assign tx_ready    = r_tx_ready;
  assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_slave_resp.sv
// Directed bench for spi_slave_resp: a behavioural SPI master drives each mode
// and the responder's outputs are compared against hand-computed words.
module tb_spi_slave_resp;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       ss, sck, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid, rx_abort, busy;

  int total = 0;
  int bad   = 0;
  int n_rxv = 0, n_txr = 0, n_und = 0, n_abt = 0;
  logic [7:0] rx_hist[$];

  spi_slave_resp #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ss(ss), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_abort(rx_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_rxv++;
      rx_hist.push_back(rx_data);
    end
    if (tx_ready)    n_txr++;
    if (tx_underrun) n_und++;
    if (rx_abort)    n_abt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Master transfer of nbits MSB-first; tx_next is presented after the first bit.
  // In CPHA=0 the last sck return to idle coincides with ss rising.
  task automatic spi_xfer(input int nbits, input logic [15:0] mo, input bit keep_sel,
                          input logic [7:0] tx_next, output logic [15:0] mi);
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    mi   = '0;
    ss   = 1'b1;
    sck  = cpol;
    repeat (H) @(negedge clk);
    ss = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = mo[i];
        repeat (H) @(negedge clk);
        sck = ~cpol;
        mi  = {mi[14:0], miso};
        repeat (H) @(negedge clk);
        sck = cpol;
        if (i == 0 && !keep_sel) ss = 1'b1;
      end else begin
        sck  = ~cpol;
        mosi = mo[i];
        repeat (H) @(negedge clk);
        sck = cpol;
        mi  = {mi[14:0], miso};
        repeat (H) @(negedge clk);
      end
      if (i == nbits - 1) tx_data = tx_next;
    end
    if (cpha && !keep_sel) ss = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  initial begin
    logic [15:0] mi;
    int rxv0, txr0, und0, abt0;

    rst_n = 1'b0; mode = 2'b00; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", miso, 1'b0);
    chk("rst_miso_oe", miso_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_tx_underrun", tx_underrun, 1'b0);
    chk("rst_rx_abort", rx_abort, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Mode 0 single word
    mode = 2'b00; tx_data = 8'hA5; tx_valid = 1'b1;
    rxv0 = n_rxv; txr0 = n_txr;
    spi_xfer(8, 16'h003C, 1'b0, 8'hA5, mi);
    chk("m0_miso_word", mi[7:0], 8'hA5);
    chk("m0_rx_data", rx_data, 8'h3C);
    chk("m0_rx_valid_cnt", n_rxv - rxv0, 1);
    chk("m0_tx_ready_cnt", n_txr - txr0, 1);
    chk("m0_idle_oe", miso_oe, 1'b0);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      mode = 2'(m); tx_data = 8'h96;
      rxv0 = n_rxv;
      spi_xfer(8, 16'h00F0, 1'b0, 8'h96, mi);
      chk($sformatf("m%0d_miso_word", m), mi[7:0], 8'h96);
      chk($sformatf("m%0d_rx_data", m), rx_data, 8'hF0);
      chk($sformatf("m%0d_rx_valid_cnt", m), n_rxv - rxv0, 1);
    end

    // Back-to-back words, mode 0 and mode 3
    for (int k = 0; k < 2; k++) begin
      mode = (k == 0) ? 2'b00 : 2'b11; tx_data = 8'h11;
      rxv0 = n_rxv; txr0 = n_txr;
      spi_xfer(16, 16'h55AA, 1'b0, 8'h22, mi);
      chk($sformatf("b2b%0d_miso", k), mi, 16'h1122);
      chk($sformatf("b2b%0d_tx_ready_cnt", k), n_txr - txr0, 2);
      chk($sformatf("b2b%0d_rx_valid_cnt", k), n_rxv - rxv0, 2);
      chk($sformatf("b2b%0d_rx_first", k), rx_hist[rx_hist.size() - 2], 8'h55);
      chk($sformatf("b2b%0d_rx_second", k), rx_data, 8'hAA);
    end

    // Underrun
    mode = 2'b00; tx_valid = 1'b0; tx_data = 8'hFF;
    und0 = n_und; txr0 = n_txr;
    spi_xfer(8, 16'h005A, 1'b0, 8'hFF, mi);
    chk("und_miso", mi[7:0], 8'h00);
    chk("und_pulse_cnt", n_und - und0, 1);
    chk("und_tx_ready_cnt", n_txr - txr0, 0);
    chk("und_rx_data", rx_data, 8'h5A);

    // Abort after 5 bits
    tx_valid = 1'b1; tx_data = 8'hC3;
    abt0 = n_abt; rxv0 = n_rxv;
    spi_xfer(5, 16'h001F, 1'b0, 8'hC3, mi);
    chk("abt_pulse_cnt", n_abt - abt0, 1);
    chk("abt_rx_valid_cnt", n_rxv - rxv0, 0);
    chk("abt_rx_data_held", rx_data, 8'h5A);
    chk("abt_miso_oe", miso_oe, 1'b0);
    chk("abt_busy", busy, 1'b0);

    // Reset mid-transfer with ss still low, then fresh transfer
    spi_xfer(3, 16'h0005, 1'b1, 8'hC3, mi);
    chk("mid_busy_before_rst", busy, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_miso_oe", miso_oe, 1'b0);
    chk("mid_rst_miso", miso, 1'b0);
    chk("mid_rst_rx_data", rx_data, 8'h00);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_no_reentry", busy, 1'b0);
    rxv0 = n_rxv;
    spi_xfer(8, 16'h0081, 1'b0, 8'hC3, mi);
    chk("post_rst_rx_data", rx_data, 8'h81);
    chk("post_rst_rx_valid_cnt", n_rxv - rxv0, 1);
    chk("post_rst_miso", mi[7:0], 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
